// File: rtl/hex_display_scanner.sv
// Hex display driver: captures an N-digit value, decodes it to a registered static 7-seg bus and a
// time-multiplexed scan bus (guard cycle per slot), with optional leading-zero blanking and blink.
// Latency: Load edge k -> Seg_all/Seg after edge k+1. No backpressure; all outputs are free-running.
module hex_display_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1024,
    parameter int BLINK_DIV  = 2**22
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [4*NUM_DIGITS-1:0]   Value,
    input  logic                      Load,
    input  logic                      Blank_lz,
    input  logic                      Blink_en,
    output logic [7*NUM_DIGITS-1:0]   Seg_all,
    output logic [6:0]                Seg,
    output logic [NUM_DIGITS-1:0]     Dig_sel
);

    localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [SCW-1:0] SCAN_LAST  = SCW'(SCAN_DIV - 1);
    localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_DIV - 1);
    localparam logic [IW-1:0]  IDX_LAST   = IW'(NUM_DIGITS - 1);

    localparam logic [6:0] BLANK = 7'h7F;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    logic [4*NUM_DIGITS-1:0] cap_q;
    logic [SCW-1:0]          scan_cnt, scan_cnt_d;
    logic [IW-1:0]           idx, idx_d;
    logic [BCW-1:0]          blink_cnt, blink_cnt_d;
    logic                    hidden, hidden_d;
    logic [7*NUM_DIGITS-1:0] seg_all_d;
    logic [6:0]              seg_d;
    logic [NUM_DIGITS-1:0]   dig_d;
    logic                    all_zero;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cap_q     <= '0;
            scan_cnt  <= '0;
            idx       <= '0;
            blink_cnt <= '0;
            hidden    <= 1'b0;
            Seg_all   <= '1;
            Seg       <= BLANK;
            Dig_sel   <= '1;
        end else begin
            if (Load) begin
                cap_q <= Value;
            end
            scan_cnt  <= scan_cnt_d;
            idx       <= idx_d;
            blink_cnt <= blink_cnt_d;
            hidden    <= hidden_d;
            Seg_all   <= seg_all_d;
            Seg       <= seg_d;
            Dig_sel   <= dig_d;
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt + SCW'(1);
        idx_d      = idx;
        if (scan_cnt == SCAN_LAST) begin
            scan_cnt_d = '0;
            idx_d      = (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end
    end

    always_comb begin
        blink_cnt_d = blink_cnt + BCW'(1);
        hidden_d    = hidden;
        if (!Blink_en) begin
            blink_cnt_d = '0;
            hidden_d    = 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt_d = '0;
            hidden_d    = ~hidden;
        end
    end

    // Walk from the most significant digit down so all_zero covers digits N-1..i.
    always_comb begin
        seg_all_d = '1;
        all_zero  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (cap_q[4*i +: 4] == 4'h0);
            if (hidden || (Blank_lz && all_zero && (i != 0))) begin
                seg_all_d[7*i +: 7] = BLANK;
            end else begin
                seg_all_d[7*i +: 7] = glyph(cap_q[4*i +: 4]);
            end
        end
    end

    // Scan outputs decode the post-edge slot so they line up with the new Seg_all.
    always_comb begin
        seg_d = BLANK;
        dig_d = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((scan_cnt_d != '0) && (idx_d == IW'(i))) begin
                seg_d    = seg_all_d[7*i +: 7];
                dig_d[i] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner with NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=8.
module tb_hex_display_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic        blink_en = 1'b0;
    logic [27:0] seg_all;
    logic [6:0]  seg;
    logic [3:0]  dig_sel;

    int checks = 0;
    int errors = 0;

    localparam logic [27:0] ALL_OFF = 28'hFFFFFFF;

    hex_display_scanner #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(8)) dut (
        .Clk(clk), .Rst(rst), .Value(value), .Load(load), .Blank_lz(blank_lz),
        .Blink_en(blink_en), .Seg_all(seg_all), .Seg(seg), .Dig_sel(dig_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        logic        blank;
        logic [27:0] exp;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [27:0] act, input logic [27:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] ref_glyph(input logic [3:0] d);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[d];
    endfunction

    function automatic logic [27:0] ref_word(input logic [15:0] v);
        return {ref_glyph(v[15:12]), ref_glyph(v[11:8]), ref_glyph(v[7:4]), ref_glyph(v[3:0])};
    endfunction

    initial begin
        vec_t vecs [9];
        logic [3:0]  scan_dig [17];
        logic [6:0]  scan_seg [17];
        logic [27:0] vis;

        vecs[0] = '{16'h1234, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
        vecs[1] = '{16'h0005, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h12}};
        vecs[2] = '{16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[3] = '{16'h0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[4] = '{16'h00A0, 1'b1, {7'h7F, 7'h7F, 7'h08, 7'h40}};
        vecs[5] = '{16'h0F0C, 1'b1, {7'h7F, 7'h0E, 7'h40, 7'h46}};
        vecs[6] = '{16'h89B6, 1'b0, {7'h00, 7'h10, 7'h03, 7'h02}};
        vecs[7] = '{16'h7ED1, 1'b1, {7'h78, 7'h06, 7'h21, 7'h79}};
        vecs[8] = '{16'h0005, 1'b0, {7'h40, 7'h40, 7'h40, 7'h12}};

        scan_dig = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF, 4'hB,
                     4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF, 4'hE};
        scan_seg = '{7'h40, 7'h19, 7'h19, 7'h7F, 7'h30, 7'h30, 7'h30, 7'h7F, 7'h24,
                     7'h24, 7'h24, 7'h7F, 7'h79, 7'h79, 7'h79, 7'h7F, 7'h19};

        // Reset takes effect asynchronously, before the first clock edge.
        #2 rst = 1'b0;
        #1;
        chk("reset_seg_all", seg_all, ALL_OFF);
        chk("reset_seg", {21'd0, seg}, {21'd0, 7'h7F});
        chk("reset_dig_sel", {24'd0, dig_sel}, {24'd0, 4'hF});
        step();
        step();
        rst   = 1'b1;
        value = 16'h1234;
        load  = 1'b1;

        // Scan from reset with a load on the first edge: Seg follows Seg_all mid-slot.
        for (int n = 0; n < 17; n++) begin
            step();
            load = 1'b0;
            chk($sformatf("scan_dig_%0d", n), {24'd0, dig_sel}, {24'd0, scan_dig[n]});
            chk($sformatf("scan_seg_%0d", n), {21'd0, seg}, {21'd0, scan_seg[n]});
        end

        for (int v = 0; v < 9; v++) begin
            value    = vecs[v].val;
            blank_lz = vecs[v].blank;
            load     = 1'b1;
            step();
            load = 1'b0;
            step();
            chk($sformatf("decode_%0d_%h", v, vecs[v].val), seg_all, vecs[v].exp);
        end

        // Blank_lz is sampled live: toggle it with cap_q = 0005.
        blank_lz = 1'b1;
        step();
        chk("blank_on", seg_all, {7'h7F, 7'h7F, 7'h7F, 7'h12});
        blank_lz = 1'b0;
        step();
        chk("blank_off", seg_all, {7'h40, 7'h40, 7'h40, 7'h12});

        vis      = {7'h40, 7'h40, 7'h40, 7'h12};
        blink_en = 1'b1;
        for (int n = 1; n <= 44; n++) begin
            step();
            if (((n - 1) / 8) % 2 == 1) begin
                chk($sformatf("blink_hidden_%0d", n), seg_all, ALL_OFF);
                chk($sformatf("blink_seg_%0d", n), {21'd0, seg}, {21'd0, 7'h7F});
            end else begin
                chk($sformatf("blink_visible_%0d", n), seg_all, vis);
            end
        end
        blink_en = 1'b0;
        step();
        step();
        chk("blink_release", seg_all, vis);

        // Continuous load: Seg_all trails Value by two edges, then freezes.
        for (int j = 0; j < 10; j++) begin
            value = 16'h0F8A + 16'(j);
            load  = 1'b1;
            step();
            if (j >= 1) begin
                chk($sformatf("track_%0d", j), seg_all, ref_word(16'h0F8A + 16'(j - 1)));
            end
        end
        load  = 1'b0;
        value = 16'hCAFE;
        step();
        chk("freeze_a", seg_all, ref_word(16'h0F93));
        step();
        chk("freeze_b", seg_all, ref_word(16'h0F93));

        // Reset mid-slot and mid-blink, then confirm all state restarted.
        blink_en = 1'b1;
        for (int j = 0; j < 5; j++) step();
        rst = 1'b0;
        #1;
        chk("midreset_seg_all", seg_all, ALL_OFF);
        chk("midreset_seg", {21'd0, seg}, {21'd0, 7'h7F});
        chk("midreset_dig_sel", {24'd0, dig_sel}, {24'd0, 4'hF});
        blink_en = 1'b0;
        #1 rst = 1'b1;
        step();
        chk("restart_dig_sel", {24'd0, dig_sel}, {24'd0, 4'hE});
        chk("restart_seg_all", seg_all, {7'h40, 7'h40, 7'h40, 7'h40});
        chk("restart_seg", {21'd0, seg}, {21'd0, 7'h40});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
